// File: rtl/flex_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : flex_tx_fifo_if
// Description : Producer/consumer bundle for the flex_tx_fifo. The FIFO uses
//               the slave view. The producer/transmitter side uses the
//               master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface flex_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                  clear;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [c_CNT_W-1:0]    count;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side: drives requests and observes status.
    modport master (
        output clear,
        output write_enable,
        output write_data,
        output read_enable,
        input  read_data,
        input  fifo_empty,
        input  fifo_full,
        input  almost_empty,
        input  almost_full,
        input  count,
        input  overflow,
        input  underflow
    );

    // FIFO side: consumes requests and reports status.
    modport slave (
        input  clear,
        input  write_enable,
        input  write_data,
        input  read_enable,
        output read_data,
        output fifo_empty,
        output fifo_full,
        output almost_empty,
        output almost_full,
        output count,
        output overflow,
        output underflow
    );
endinterface
`default_nettype wire

// File: rtl/flex_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flex_tx_fifo
// Description : Parametrised first-word-fall-through transmit FIFO. It has an
//               occupancy count, programmable almost-full/almost-empty
//               flags, a synchronous flush, and sticky overflow/underflow
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    flex_tx_fifo_if.slave        bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF      = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE      = c_CNT_W'(AE_LEVEL);

    // Storage and registered state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q,  count_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    // Accept decisions, taken on the pre-edge state
    logic w_not_empty;
    logic w_not_full;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_not_empty = (count_q != '0);
    assign w_not_full  = (count_q != c_FULL);
    // A read while full frees a slot in the same edge, so the write can also
    // be accepted. A write while empty does not make a read possible in the
    // same cycle.
    assign w_rd_acc    = bus.read_enable  & w_not_empty;
    assign w_wr_acc    = bus.write_enable & (w_not_full | w_rd_acc);

    // Next-state computation for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
            if (bus.write_enable && !w_wr_acc) begin
                overflow_d = 1'b1;
            end
            if (bus.read_enable && !w_rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write. The contents are not reset. Only accepted writes that
    // are not overridden by reset or flush touch the array.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clear && w_wr_acc) begin
            mem_q[wr_ptr_q] <= bus.write_data;
        end
    end

    // Output decodes. They use registered state only, so there is no path
    // from any input to any output.
    always_comb begin
        bus.read_data    = w_not_empty ? mem_q[rd_ptr_q] : '0;
        bus.fifo_empty   = ~w_not_empty;
        bus.fifo_full    = ~w_not_full;
        bus.almost_empty = (count_q <= c_AE);
        bus.almost_full  = (count_q >= c_AF);
        bus.count        = count_q;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_flex_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_tx_fifo
// Description : Self-checking bench for flex_tx_fifo (8x8, AF=6, AE=1).
//               A queue-based reference model is compared against every
//               output on each falling edge. Directed scenarios add
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_tx_fifo;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 8;
    localparam int c_AF    = 6;
    localparam int c_AE    = 1;

    logic clk;
    logic rst;

    flex_tx_fifo_if #(.DATA_WIDTH(c_DW), .DEPTH(c_DEPTH)) bus ();

    flex_tx_fifo #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .AF_LEVEL   (c_AF),
        .AE_LEVEL   (c_AE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the FIFO contents as a queue plus the sticky flags
    logic [c_DW-1:0] m_q [$];
    bit              m_ovf = 1'b0;
    bit              m_udf = 1'b0;
    bit              m_valid = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit we,
                              input logic [c_DW-1:0] wd, input bit re);
        bit rd_ok;
        bit wr_ok;
        if (r || c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            rd_ok = re && (m_q.size() > 0);
            wr_ok = we && ((m_q.size() < c_DEPTH) || rd_ok);
            if (re && !rd_ok) m_udf = 1'b1;
            if (we && !wr_ok) m_ovf = 1'b1;
            if (rd_ok) void'(m_q.pop_front());
            if (wr_ok) m_q.push_back(wd);
        end
    endtask

    // Drives one clock cycle of stimulus and advances the model at the edge.
    task automatic cycle(input bit r, input bit c, input bit we,
                         input logic [c_DW-1:0] wd, input bit re);
        @(negedge clk);
        rst              = r;
        bus.clear        = c;
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.read_enable  = re;
        @(posedge clk);
        model_step(r, c, we, wd, re);
        #1;
        rst              = 1'b0;
        bus.clear        = 1'b0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic wr(input logic [c_DW-1:0] d);
        cycle(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    // Continuous comparison of every output against the model
    always @(negedge clk) begin
        if (m_valid) begin
            int sz;
            sz = m_q.size();
            check("count",        longint'(bus.count),        longint'(sz));
            check("read_data",    longint'(bus.read_data),    (sz > 0) ? longint'(m_q[0]) : 0);
            check("fifo_empty",   longint'(bus.fifo_empty),   longint'(sz == 0));
            check("fifo_full",    longint'(bus.fifo_full),    longint'(sz == c_DEPTH));
            check("almost_empty", longint'(bus.almost_empty), longint'(sz <= c_AE));
            check("almost_full",  longint'(bus.almost_full),  longint'(sz >= c_AF));
            check("overflow",     longint'(bus.overflow),     longint'(m_ovf));
            check("underflow",    longint'(bus.underflow),    longint'(m_udf));
        end
    end

    initial begin
        logic [c_DW-1:0] drain_exp [8];
        int wp, rp, cp;

        rst              = 1'b1;
        bus.clear        = 1'b0;
        bus.write_enable = 1'b0;
        bus.write_data   = '0;
        bus.read_enable  = 1'b0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
        m_valid = 1'b1;
        check("rst_count",  longint'(bus.count), 0);
        check("rst_empty",  longint'(bus.fifo_empty), 1);
        check("rst_full",   longint'(bus.fifo_full), 0);
        check("rst_ae",     longint'(bus.almost_empty), 1);
        check("rst_af",     longint'(bus.almost_full), 0);
        check("rst_rdata",  longint'(bus.read_data), 0);

        // Single write is visible immediately after the edge
        wr(8'h0F);
        check("w1_rdata", longint'(bus.read_data), 'h0F);
        check("w1_count", longint'(bus.count), 1);
        check("w1_empty", longint'(bus.fifo_empty), 0);
        check("w1_ae",    longint'(bus.almost_empty), 1);

        // Two entries, two reads
        wr(8'hF0);
        check("w2_rdata", longint'(bus.read_data), 'h0F);
        rd();
        check("r1_rdata", longint'(bus.read_data), 'hF0);
        rd();
        check("r2_rdata", longint'(bus.read_data), 'h00);
        check("r2_empty", longint'(bus.fifo_empty), 1);
        check("r2_udf",   longint'(bus.underflow), 0);

        // Fill to full, almost_full threshold, then overflow
        for (int i = 1; i <= 8; i++) begin
            wr(8'(i));
            if (i == 5) check("af_before", longint'(bus.almost_full), 0);
            if (i == 6) check("af_after",  longint'(bus.almost_full), 1);
            if (i == 7) check("full_7",    longint'(bus.fifo_full), 0);
        end
        check("full_8",  longint'(bus.fifo_full), 1);
        check("count_8", longint'(bus.count), 8);
        wr(8'hAA);
        check("ovf_set",   longint'(bus.overflow), 1);
        check("ovf_count", longint'(bus.count), 8);
        check("ovf_head",  longint'(bus.read_data), 'h01);

        // Simultaneous read/write on a full FIFO, then drain through the wrap
        cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        check("rw_full_count", longint'(bus.count), 8);
        check("rw_full_rdata", longint'(bus.read_data), 'h02);
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'(i + 2);
        drain_exp[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check("drain", longint'(bus.read_data), longint'(drain_exp[i]));
            rd();
        end
        check("drained_empty", longint'(bus.fifo_empty), 1);

        // Simultaneous read/write on an empty FIFO
        cycle(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        check("rw_empty_udf",   longint'(bus.underflow), 1);
        check("rw_empty_count", longint'(bus.count), 1);
        check("rw_empty_rdata", longint'(bus.read_data), 'h33);

        // Flush with a write pending: both sticky flags are set beforehand
        for (int i = 0; i < 4; i++) wr(8'(8'h40 + i));
        check("pre_clr_count", longint'(bus.count), 5);
        cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        check("clr_count", longint'(bus.count), 0);
        check("clr_empty", longint'(bus.fifo_empty), 1);
        check("clr_ovf",   longint'(bus.overflow), 0);
        check("clr_udf",   longint'(bus.underflow), 0);

        // Same using reset
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
        rd();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        check("rst2_count", longint'(bus.count), 0);
        check("rst2_empty", longint'(bus.fifo_empty), 1);
        check("rst2_rdata", longint'(bus.read_data), 0);

        // Randomized traffic in write-heavy, read-heavy and balanced phases
        for (int i = 0; i < 3000; i++) begin
            int ph;
            bit r, c, we, re;
            ph = (i / 250) % 3;
            wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            cp = $urandom_range(0, 299);
            r  = (cp == 0);
            c  = (cp == 1) || (cp == 2);
            we = ($urandom_range(0, 99) < wp);
            re = ($urandom_range(0, 99) < rp);
            cycle(r, c, we, 8'($urandom), re);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
